csa_multi_accumulator: RTL and testbench

- Parametrised multi-operand carry-save accumulator with a valid/ready input and a valid/ready output.
- Each input beat carries NUM_OPS operands. They are compressed, together with the running sum/carry rows, through a 3:2 counter tree and kept in redundant form across beats.
- On the last beat, a multi-cycle chunked carry-propagate stage resolves the result into binary.
- Intended as the operand-accumulation engine for Montgomery iterations; it generalises the fixed 6:2 compressor to arbitrary width and operand count, and adds accumulation, handshake and resolve sequencing.

---
 rtl/csa_multi_accumulator.sv | 125 ++++++++++++
 tb/tb_csa_multi_accumulator.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/csa_multi_accumulator.sv
// Multi-operand carry-save accumulator with chunked carry-propagate resolve.
// Ports: clk, rst_n, in_valid/in_ready/in_ops/in_last, out_valid/out_ready/out_data.
module csa_multi_accumulator #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_OPS    = 4,
  parameter int GUARD      = 4,
  parameter int CPA_CHUNK  = 12
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_OPS*DATA_WIDTH-1:0] in_ops,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH+GUARD-1:0]   out_data
);

  localparam int AW = DATA_WIDTH + GUARD;
  localparam int K  = AW / CPA_CHUNK;
  localparam int CW = $clog2(K + 1);

  typedef enum logic [1:0] {
    ST_ACC,
    ST_RES,
    ST_OUT
  } state_e;

  state_e          state_q;
  logic [AW-1:0]   sum_q;
  logic [AW-1:0]   carry_q;
  logic [CW-1:0]   cnt_q;
  logic            cy_q;
  logic [AW-1:0]   out_q;
  logic            out_valid_q;

  logic [AW-1:0]   sum_d;
  logic [AW-1:0]   carry_d;

  // Redundant rows after each 3:2 stage; stage 0 is the stored pair.
  logic [AW-1:0] cs_s [NUM_OPS+1];
  logic [AW-1:0] cs_c [NUM_OPS+1];

  assign cs_s[0] = sum_q;
  assign cs_c[0] = carry_q;

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_csa
    logic [AW-1:0] op;
    logic [AW-1:0] maj;
    assign op  = AW'(in_ops[i*DATA_WIDTH +: DATA_WIDTH]);
    assign maj = (cs_s[i] & cs_c[i])
               | (cs_s[i] & op)
               | (cs_c[i] & op);
    assign cs_s[i+1] = cs_s[i] ^ cs_c[i] ^ op;
    // Carry weight doubles; the bit leaving the MSB is dropped (mod 2^AW).
    assign cs_c[i+1] = {maj[AW-2:0], 1'b0};
  end

  assign sum_d   = cs_s[NUM_OPS];
  assign carry_d = cs_c[NUM_OPS];

  // The counter also visits K as a settle step; clamp so the
  // chunk select never leaves the row.
  logic [CW-1:0]      idx;
  logic [CPA_CHUNK:0] chunk_d;

  assign idx = (cnt_q < CW'(K)) ? cnt_q : '0;

  always_comb begin
    chunk_d = {1'b0, sum_q[int'(idx)*CPA_CHUNK +: CPA_CHUNK]}
            + {1'b0, carry_q[int'(idx)*CPA_CHUNK +: CPA_CHUNK]}
            + {{CPA_CHUNK{1'b0}}, cy_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACC;
      sum_q       <= '0;
      carry_q     <= '0;
      cnt_q       <= '0;
      cy_q        <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_ACC: begin
          if (in_valid) begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            if (in_last) begin
              state_q <= ST_RES;
              cnt_q   <= '0;
              cy_q    <= 1'b0;
            end
          end
        end
        ST_RES: begin
          if (cnt_q == CW'(K)) begin
            state_q     <= ST_OUT;
            out_valid_q <= 1'b1;
          end else begin
            out_q[int'(idx)*CPA_CHUNK +: CPA_CHUNK] <= chunk_d[CPA_CHUNK-1:0];
            cy_q  <= chunk_d[CPA_CHUNK];
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            carry_q     <= '0;
            state_q     <= ST_ACC;
          end
        end
        default: state_q <= ST_ACC;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = out_valid_q;
  assign out_data  = out_q;

endmodule

// File: tb/tb_csa_multi_accumulator.sv
// Directed bench for csa_multi_accumulator.
// Hand-computed sums checked through one compare task.
module tb_csa_multi_accumulator;

  localparam int DW = 32;
  localparam int NO = 4;
  localparam int AW = 36;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [NO*DW-1:0]  in_ops;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [AW-1:0]     out_data;

  int nvec;
  int nerr;

  csa_multi_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ops    (in_ops),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  function automatic logic [NO*DW-1:0] pack(input logic [DW-1:0] a,
                                           input logic [DW-1:0] b,
                                           input logic [DW-1:0] c,
                                           input logic [DW-1:0] d);
    return {d, c, b, a};
  endfunction

  // Present one beat and hold it until accepted (bounded).
  task automatic beat(input logic [NO*DW-1:0] ops, input logic last);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_ops   = ops;
    in_last  = last;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!ok) chk("beat_accept_timeout", 64'd0, 64'd1);
  endtask

  // Edges after the accepting edge until out_valid; 0 on timeout.
  task automatic wait_out(output int lat);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    if (lat == 0) chk("out_valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("take_valid_low", 64'(out_valid), 64'd0);
    chk("take_ready_high", 64'(in_ready), 64'd1);
  endtask

  initial begin
    int lat;
    logic [AW-1:0] held;
    nvec      = 0;
    nerr      = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_ops    = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_data", 64'(out_data), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single beat {1,2,3,4}
    beat(pack(1, 2, 3, 4), 1'b1);
    wait_out(lat);
    chk("single_latency", 64'(lat), 64'd4);
    chk("single_data", 64'(out_data), 64'h0_0000_000A);
    take();

    // Three beats of all-ones operands
    for (int b = 0; b < 3; b++)
      beat(pack('1, '1, '1, '1), b == 2);
    wait_out(lat);
    chk("three_latency", 64'(lat), 64'd4);
    chk("three_data", 64'(out_data), 64'hB_FFFF_FFF4);
    take();

    // Five beats wraps past 36 bits
    for (int b = 0; b < 5; b++)
      beat(pack('1, '1, '1, '1), b == 4);
    wait_out(lat);
    chk("wrap_data", 64'(out_data), 64'h3_FFFF_FFEC);

    // Backpressure in OUT
    held = out_data;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_data", 64'(out_data), 64'(held));
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    take();
    beat(pack(0, 0, 0, 7), 1'b1);
    wait_out(lat);
    chk("cleared_data", 64'(out_data), 64'd7);
    take();

    // Beat offered during RESOLVE is ignored
    beat(pack(1, 1, 1, 1), 1'b1);
    in_valid = 1'b1;
    in_ops   = pack(9, 9, 9, 9);
    in_last  = 1'b1;
    for (int n = 0; n < 2; n++) begin
      chk("resolve_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_out(lat);
    chk("ignore_data", 64'(out_data), 64'd4);
    take();

    // Reset mid-RESOLVE discards the transaction
    beat(pack(3, 3, 3, 3), 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_ready", 64'(in_ready), 64'd1);
    chk("midrst_data", 64'(out_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    beat(pack(5, 0, 0, 0), 1'b1);
    wait_out(lat);
    chk("post_rst_data", 64'(out_data), 64'd5);
    take();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
